// File: rtl/nx_arb_pkg.sv
// nx_arb_pkg: shared types and constants for the Nexus message arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / SERVE_A / SERVE_B)
//   SRC_A, SRC_B : values driven on ob_src_o to tag a message's origin
//   burst_width  : width of the burst counter, never narrower than 3 bits
package nx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic int burst_width(input int max_burst);
    int w;
    w = $clog2(max_burst + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/nx_msg_arbiter.sv
// nx_msg_arbiter: merges two valid/ready message streams (A = ctrl, B = mesh)
// into one registered output slot. A wins ties from IDLE; an owner holds the
// grant for at most MAX_BURST consecutive accepts while the other source waits.
//
// Ports
//   clk_i, rstn_i                   clock, asynchronous active-low reset
//   a_data_i/a_valid_i/a_ready_o    source A stream
//   b_data_i/b_valid_i/b_ready_o    source B stream
//   ob_data_o/ob_src_o/ob_valid_o/ob_ready_i  merged stream (src 0=A, 1=B)
//   count_clear_i, count_a_o, count_b_o       per-source accept counters,
//                                             only when NX_ARB_STATS_EN is defined
//   idle_o                          no message held and no input valid
//
// Build option: define NX_ARB_STATS_EN to add the saturating statistics counters.
module nx_msg_arbiter
  import nx_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 31,
  parameter int MAX_BURST   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic [DATA_WIDTH-1:0]  ob_data_o,
  output logic                   ob_src_o,
  output logic                   ob_valid_o,
  input  logic                   ob_ready_i,
`ifdef NX_ARB_STATS_EN
  input  logic                   count_clear_i,
  output logic [COUNT_WIDTH-1:0] count_a_o,
  output logic [COUNT_WIDTH-1:0] count_b_o,
`endif
  output logic                   idle_o
);

  localparam int                 BURST_W   = burst_width(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e             state_q;
  logic [BURST_W-1:0]     burst_q;
  logic [DATA_WIDTH-1:0]  data_p0;
  logic                   src_p0;
  logic                   vld_p0;

  logic slot_free;
  logic burst_full;
  logic grant_a;
  logic grant_b;
  logic accept_a;
  logic accept_b;
  logic accept;
  logic owner_same;

  assign slot_free  = !vld_p0 || ob_ready_i;
  assign burst_full = (burst_q == BURST_MAX);

  // The owner keeps the grant unless the other source is waiting and the
  // burst limit is reached; an idle owner hands over without a bubble.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      SERVE_A: begin
        if (a_valid_i && !(b_valid_i && burst_full)) grant_a = 1'b1;
        else if (b_valid_i)                          grant_b = 1'b1;
      end
      SERVE_B: begin
        if (b_valid_i && !(a_valid_i && burst_full)) grant_b = 1'b1;
        else if (a_valid_i)                          grant_a = 1'b1;
      end
      default: begin
        if (a_valid_i)      grant_a = 1'b1;
        else if (b_valid_i) grant_b = 1'b1;
      end
    endcase
  end

  // Readies are forced low while reset is asserted so no handshake is seen.
  assign a_ready_o  = rstn_i && slot_free && grant_a;
  assign b_ready_o  = rstn_i && slot_free && grant_b;
  assign accept_a   = a_valid_i && a_ready_o;
  assign accept_b   = b_valid_i && b_ready_o;
  assign accept     = accept_a || accept_b;
  assign owner_same = (accept_a && state_q == SERVE_A) ||
                      (accept_b && state_q == SERVE_B);

  // Stage p0: output slot, grant state and burst counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      burst_q <= '0;
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      src_p0  <= SRC_A;
    end else if (slot_free) begin
      vld_p0 <= accept;
      if (accept) begin
        data_p0 <= accept_a ? a_data_i : b_data_i;
        src_p0  <= accept_a ? SRC_A : SRC_B;
      end
      if (accept_a)      state_q <= SERVE_A;
      else if (accept_b) state_q <= SERVE_B;
      else               state_q <= IDLE;
      if (!accept)         burst_q <= '0;
      else if (!owner_same) burst_q <= BURST_W'(1);
      else if (!burst_full) burst_q <= burst_q + BURST_W'(1);
    end
  end

  assign ob_data_o  = data_p0;
  assign ob_src_o   = src_p0;
  assign ob_valid_o = vld_p0;
  assign idle_o     = !rstn_i || (!vld_p0 && !a_valid_i && !b_valid_i);

`ifdef NX_ARB_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] cnt_a_q;
  logic [COUNT_WIDTH-1:0] cnt_b_q;

  // A clear coinciding with an accept restarts the count at one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (count_clear_i)                   cnt_a_q <= accept_a ? COUNT_WIDTH'(1) : '0;
      else if (accept_a && cnt_a_q != CNT_MAX) cnt_a_q <= cnt_a_q + COUNT_WIDTH'(1);
      if (count_clear_i)                   cnt_b_q <= accept_b ? COUNT_WIDTH'(1) : '0;
      else if (accept_b && cnt_b_q != CNT_MAX) cnt_b_q <= cnt_b_q + COUNT_WIDTH'(1);
    end
  end

  assign count_a_o = cnt_a_q;
  assign count_b_o = cnt_b_q;
`endif

endmodule

// File: doc/nx_msg_arbiter.md
NX_MSG_ARBITER -- requirements
Module: nx_msg_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 31, Nexus message width.
REQ-002 Parameter MAX_BURST, default 4, consecutive grants to one source while the other is waiting.
REQ-003 Parameter COUNT_WIDTH, default 16, statistics counter width.
REQ-004 clk_i  in  1  sole clock; all logic is rising-edge.
REQ-005 rstn_i  in  1  asynchronous active-low reset.
REQ-006 a_data_i / a_valid_i / a_ready_o  in / in / out  DATA_WIDTH / 1 / 1  source A stream (ctrl).
REQ-007 b_data_i / b_valid_i / b_ready_o  in / in / out  DATA_WIDTH / 1 / 1  source B stream (mesh).
REQ-008 ob_data_o / ob_src_o / ob_valid_o / ob_ready_i  out / out / out / in  DATA_WIDTH / 1 / 1 / 1  merged stream; ob_src_o is 0 for A, 1 for B.
REQ-009 idle_o  out  1  high when no message is held and both valid inputs are low.
REQ-010 count_clear_i  in  1; count_a_o / count_b_o  out  COUNT_WIDTH  (present only under NX_ARB_STATS_EN).

Function
REQ-011 Transfer on any port SHALL occur when valid and ready are both high on the same rising edge.
REQ-012 Output SHALL be a single registered slot; ob_data_o, ob_src_o and ob_valid_o SHALL come straight from flops.
REQ-013 Slot is free when ob_valid_o is low or ob_ready_i is high; at most one input ready SHALL be high, and only when the slot is free.
REQ-014 Latency: a message accepted at edge N SHALL appear on ob_valid_o after edge N; back-to-back acceptance at one message per cycle SHALL be sustained while ob_ready_i stays high.
REQ-015 FSM states: IDLE, SERVE_A, SERVE_B; reset state IDLE.
REQ-016 IDLE: A valid alone -> SERVE_A; B valid alone -> SERVE_B; both valid -> SERVE_A; neither valid -> remain in IDLE.
REQ-017 SERVE_x: grant x while x is valid; when x is not valid and the other source is valid, switch to the other source in the same cycle with no bubble; when neither is valid -> IDLE.
REQ-018 A 3-bit-or-wider burst counter SHALL count accepts of the current owner and clear on owner change or IDLE.
REQ-019 When both sources are valid and the burst count equals MAX_BURST, the next grant SHALL go to the other source.
REQ-020 While the other source is invalid, the burst counter SHALL saturate at MAX_BURST and the owner SHALL keep its grant.
REQ-021 The FSM and burst counter SHALL advance only on cycles where the slot is free; ob_ready_i low SHALL freeze grant state, and ob_* SHALL hold stable.
REQ-022 Inputs SHALL never be dropped or duplicated; output order per source SHALL equal input order.

Reset
REQ-023 On rstn_i low, outputs SHALL immediately take these values: ob_valid_o=0, ob_data_o=0, ob_src_o=0, a_ready_o=0, b_ready_o=0, idle_o=1, counters=0, FSM=IDLE, burst=0.
REQ-024 Reset mid-transfer SHALL discard the held message; the first cycle after release behaves as IDLE.

Configuration
REQ-025 With NX_ARB_STATS_EN defined: count_a_o and count_b_o SHALL count accepted messages per source, saturate at all-ones, and be zeroed by count_clear_i; clear together with an accept SHALL give 1.
REQ-026 Without NX_ARB_STATS_EN: the count ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package nx_arb_pkg SHALL hold the FSM state enum (IDLE/SERVE_A/SERVE_B) and the source-ID constants (SRC_A=0, SRC_B=1).
REQ-028 The design SHALL be a single module with no sub-modules; the output slot is inline.

Verification
REQ-029 Reset release, no traffic -> idle_o=1, ob_valid_o=0, both readys low.
REQ-030 A sends 0x11,0x22,0x33 with ob_ready_i=1 -> ob_data_o shows 0x11,0x22,0x33 on consecutive cycles, starting one cycle after the first accept, with ob_src_o=0.
REQ-031 A and B each hold 10 messages valid, MAX_BURST=4, ob_ready_i=1 -> output source sequence AAAABBBBAAAABBBBAABB, no idle cycles.
REQ-032 B streams, ob_ready_i low for 5 cycles -> ob_data_o stable, b_ready_o=0 throughout, no loss after resume.
REQ-033 Stats build: 65540 A accepts with COUNT_WIDTH=16 -> count_a_o=0xFFFF; count_clear_i asserted with a simultaneous accept -> count_a_o=1.
REQ-034 rstn_i pulsed low while ob_valid_o=1 -> ob_valid_o=0 asynchronously, and the held message is never emitted.
